// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment display blocks: active-high glyphs
// in {g,f,e,d,c,b,a} order, the all-dark pattern and the scanner state type.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [6:0] SEG_OFF = 7'h00;

    typedef enum logic [1:0] {
        SCAN_OFF   = 2'd0,
        SCAN_BLANK = 2'd1,
        SCAN_SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-high {g..a} glyph decoder; b and d are
// the lowercase forms so they stay distinguishable from 8 and 0.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph
);

    // Nibble lookup
    always_comb begin
        glyph = SEG_OFF;
        case (nibble)
            4'h0:    glyph = GLYPH_0;
            4'h1:    glyph = GLYPH_1;
            4'h2:    glyph = GLYPH_2;
            4'h3:    glyph = GLYPH_3;
            4'h4:    glyph = GLYPH_4;
            4'h5:    glyph = GLYPH_5;
            4'h6:    glyph = GLYPH_6;
            4'h7:    glyph = GLYPH_7;
            4'h8:    glyph = GLYPH_8;
            4'h9:    glyph = GLYPH_9;
            4'hA:    glyph = GLYPH_A;
            4'hB:    glyph = GLYPH_B;
            4'hC:    glyph = GLYPH_C;
            4'hD:    glyph = GLYPH_D;
            4'hE:    glyph = GLYPH_E;
            4'hF:    glyph = GLYPH_F;
            default: glyph = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed hex scanner for a common-anode display bank, stepped by the
// rising edges of a divided scan clock. Define SEVEN_SEG_ZERO_BLANK_EN to blank leading zeros.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W         = $clog2(NUM_DIGITS)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    scan_clk,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IDX_W-1:0]        digit_idx
);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0]      ONE_IDX  = IDX_W'(1);
    localparam logic [6:0]            SEG_IDLE = SEG_OFF ^ {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_IDLE  = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

    logic                    sync1_r, sync2_r, prev_r;
    logic                    adv_s;
    scan_state_e             state_r, state_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic                    pend_r, pend_s;
    logic [4*NUM_DIGITS-1:0] snap_val_r, snap_val_s;
    logic [NUM_DIGITS-1:0]   snap_dp_r, snap_dp_s;
    logic [3:0]              nib_s;
    logic [6:0]              glyph_s, lit_glyph_s;
    logic [6:0]              seg_nxt_s;
    logic                    dp_nxt_s;
    logic [NUM_DIGITS-1:0]   an_nxt_s;

    // scan_clk is asynchronous data: two flops to settle it, one to find its rising edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= scan_clk;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign adv_s = sync2_r & ~prev_r;

    // Next-state logic: digit stepping, pending advance and frame snapshot capture
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        pend_s     = pend_r;
        snap_val_s = snap_val_r;
        snap_dp_s  = snap_dp_r;
        if (!enable) begin
            state_s = SCAN_OFF;
            idx_s   = '0;
            pend_s  = 1'b0;
        end else begin
            case (state_r)
                SCAN_OFF: begin
                    // an advance coinciding with start-up is deliberately dropped
                    state_s    = SCAN_BLANK;
                    idx_s      = '0;
                    pend_s     = 1'b0;
                    snap_val_s = value_in;
                    snap_dp_s  = dp_in;
                end
                SCAN_BLANK: begin
                    state_s = SCAN_SHOW;
                    pend_s  = pend_r | adv_s;
                end
                SCAN_SHOW: begin
                    if (adv_s || pend_r) begin
                        state_s = SCAN_BLANK;
                        pend_s  = 1'b0;
                        if (idx_r == LAST_IDX) begin
                            idx_s      = '0;
                            snap_val_s = value_in;
                            snap_dp_s  = dp_in;
                        end else begin
                            idx_s = idx_r + ONE_IDX;
                        end
                    end else begin
                        state_s = SCAN_SHOW;
                    end
                end
                default: begin
                    state_s = SCAN_OFF;
                    idx_s   = '0;
                    pend_s  = 1'b0;
                end
            endcase
        end
    end

    // State, index and snapshot registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= SCAN_OFF;
            idx_r      <= '0;
            pend_r     <= 1'b0;
            snap_val_r <= '0;
            snap_dp_r  <= '0;
        end else begin
            state_r    <= state_s;
            idx_r      <= idx_s;
            pend_r     <= pend_s;
            snap_val_r <= snap_val_s;
            snap_dp_r  <= snap_dp_s;
        end
    end

    assign digit_idx = idx_r;

    // Outputs are decoded from the next state so the pins line up with state_r
    assign nib_s = snap_val_s[4*idx_s +: 4];

    hex_to_seg u_hex_to_seg (
        .nibble (nib_s),
        .glyph  (glyph_s)
    );

`ifdef SEVEN_SEG_ZERO_BLANK_EN
    function automatic logic is_leading_zero(input logic [4*NUM_DIGITS-1:0] v,
                                             input logic [IDX_W-1:0]        i);
        logic z;
        z = (i != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            z = z & ((k < int'(i)) | (v[4*k +: 4] == 4'h0));
        end
        return z;
    endfunction

    assign lit_glyph_s = is_leading_zero(snap_val_s, idx_s) ? SEG_OFF : glyph_s;
`else
    assign lit_glyph_s = glyph_s;
`endif

    // Pin values for the coming cycle, polarity applied here
    always_comb begin
        an_nxt_s  = AN_IDLE;
        seg_nxt_s = SEG_IDLE;
        dp_nxt_s  = DP_IDLE;
        if (state_s == SCAN_SHOW) begin
            an_nxt_s  = (AN_ONE << idx_s) ^ AN_IDLE;
            seg_nxt_s = lit_glyph_s ^ {7{SEG_ACTIVE_LOW}};
            dp_nxt_s  = snap_dp_s[idx_s] ^ SEG_ACTIVE_LOW;
        end else begin
            an_nxt_s  = AN_IDLE;
            seg_nxt_s = SEG_IDLE;
            dp_nxt_s  = DP_IDLE;
        end
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_out  <= AN_IDLE;
            seg_out <= SEG_IDLE;
            dp_out  <= DP_IDLE;
        end else begin
            an_out  <= an_nxt_s;
            seg_out <= seg_nxt_s;
            dp_out  <= dp_nxt_s;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, active-low pins) against
// a frame-level display model; honours SEVEN_SEG_ZERO_BLANK_EN.
module tb_seven_seg_scanner;

    localparam int N = 4;

    logic          clock = 1'b0;
    logic          reset, scan_clk, enable;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [3:0]    an_out;
    logic [1:0]    digit_idx;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // display model: dark / one-cycle gap / lit digit, advances owed across a gap
    bit          m_lit, m_gap, m_owed;
    int          m_digit;
    logic [15:0] m_frame;
    logic [3:0]  m_dps;
    bit          h1, h2, h3;

    int scan_period = 0;
    int scan_cnt    = 0;
    bit scan_rand   = 1'b0;
    int dark;

    seven_seg_scanner #(.NUM_DIGITS(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
        .clock     (clock),
        .reset     (reset),
        .scan_clk  (scan_clk),
        .enable    (enable),
        .value_in  (value_in),
        .dp_in     (dp_in),
        .seg_out   (seg_out),
        .dp_out    (dp_out),
        .an_out    (an_out),
        .digit_idx (digit_idx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_lit = 1'b0; m_gap = 1'b0; m_owed = 1'b0; m_digit = 0;
        m_frame = 16'h0000; m_dps = 4'h0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    task automatic model_step();
        bit adv;
        adv = h2 & ~h3;   // rising edge seen two samples late
        if (!enable) begin
            m_lit = 1'b0; m_gap = 1'b0; m_owed = 1'b0; m_digit = 0;
        end else if (!m_lit && !m_gap) begin
            m_gap = 1'b1; m_digit = 0; m_owed = 1'b0; m_frame = value_in; m_dps = dp_in;
        end else if (m_gap) begin
            m_gap = 1'b0; m_lit = 1'b1; m_owed = adv;
        end else if (adv || m_owed) begin
            m_lit = 1'b0; m_gap = 1'b1; m_owed = 1'b0;
            m_digit = (m_digit + 1) % N;
            if (m_digit == 0) begin
                m_frame = value_in; m_dps = dp_in;
            end
        end
        h3 = h2; h2 = h1; h1 = scan_clk;
    endtask

    task automatic check_model();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        bit         blank;
        blank = 1'b0;
        if (m_lit) begin
`ifdef SEVEN_SEG_ZERO_BLANK_EN
            blank = (m_digit != 0) && ((m_frame >> (4 * m_digit)) == 16'h0000);
`endif
            e_an  = ~(4'b0001 << m_digit);
            e_seg = blank ? 7'h7F : ~glyph_tab[(m_frame >> (4 * m_digit)) & 16'h000F];
            e_dp  = ~m_dps[m_digit];
        end else begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end
        check("an_out", an_out, e_an);
        check("seg_out", seg_out, e_seg);
        check("dp_out", dp_out, e_dp);
        check("digit_idx", digit_idx, m_digit);
    endtask

    task automatic tick();
        if (scan_period > 0) begin
            scan_cnt++;
            if (scan_cnt >= scan_period) begin
                scan_cnt = 0;
                scan_clk = ~scan_clk;
            end
        end else if (scan_rand && $urandom_range(0, 3) == 0) begin
            scan_clk = ~scan_clk;
        end
        model_step();
        @(posedge clock);
        @(negedge clock);
        check_model();
    endtask

    task automatic wait_lit(input string tag);
        for (int i = 0; i < 200 && !m_lit; i++) tick();
        check(tag, m_lit, 1);
    endtask

    initial begin
        reset = 1'b1; scan_clk = 1'b0; enable = 1'b0; value_in = 16'h0000; dp_in = 4'h0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_an", an_out, 4'hF);
        check("reset_seg", seg_out, 7'h7F);
        check("reset_dp", dp_out, 1'b1);
        check("reset_idx", digit_idx, 2'd0);
        reset = 1'b0;

        // 1: basic scan of 1234
        value_in = 16'h1234; enable = 1'b1; scan_period = 8;
        tick();
        check("t1_blank_an", an_out, 4'hF);
        tick();
        check("t1_d0_an", an_out, 4'b1110);
        check("t1_d0_seg", seg_out, 7'b0011001);
        dark = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (an_out == 4'hF) dark++;
            else begin
                if (dark != 0) check("t1_gap_len", dark, 1);
                dark = 0;
            end
        end

        // 2: mid-frame value change stays hidden until wrap
        for (int i = 0; i < 200 && !(m_lit && m_digit == 2); i++) tick();
        check("t2_reach_d2", digit_idx, 2'd2);
        value_in = 16'hABCD;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_lit && m_digit == 3 && m_frame == 16'h1234) check("t2_old_d3", seg_out, 7'b1111001);
        end

        // 3: enable drop and restart with a fresh snapshot
        wait_lit("t3_wait_lit");
        enable = 1'b0;
        tick();
        check("t3_off_an", an_out, 4'hF);
        check("t3_off_seg", seg_out, 7'h7F);
        repeat (3) tick();
        value_in = 16'($urandom); dp_in = 4'($urandom);
        enable = 1'b1;
        tick();
        tick();
        check("t3_restart_an", an_out, 4'b1110);
        for (int i = 0; i < 150; i++) tick();

        // 4: asynchronous reset between edges
        wait_lit("t4_wait_lit");
        #2 reset = 1'b1;
        #1;
        check("t4_async_an", an_out, 4'hF);
        check("t4_async_seg", seg_out, 7'h7F);
        check("t4_async_dp", dp_out, 1'b1);
        check("t4_async_idx", digit_idx, 2'd0);
        model_reset();
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) tick();

        // 5a: stuck scan clock holds the current digit
        scan_period = 0; scan_clk = 1'b1;
        for (int i = 0; i < 100; i++) tick();
        // 5b: advance landing in the blanking cycle is deferred, not lost
        enable = 1'b0; scan_clk = 1'b0;
        repeat (4) tick();
        scan_clk = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        tick();
        check("t5_d0_shown", an_out, 4'b1110);
        tick();
        check("t5_defer_idx", digit_idx, 2'd1);
        check("t5_defer_gap", an_out, 4'hF);
        tick();
        check("t5_d1_shown", an_out, 4'b1101);
        repeat (10) tick();

        // 6: leading zeros (blanked only when the feature is built in)
        enable = 1'b0;
        tick();
        value_in = 16'h0040; dp_in = 4'b1000; enable = 1'b1; scan_period = 4;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (m_lit && m_digit == 3) begin
`ifdef SEVEN_SEG_ZERO_BLANK_EN
                check("t6_d3_seg", seg_out, 7'h7F);
`else
                check("t6_d3_seg", seg_out, 7'b1000000);
`endif
                check("t6_d3_dp", dp_out, 1'b0);
            end
            if (m_lit && m_digit == 1) check("t6_d1_seg", seg_out, 7'b0011001);
        end

        // 7: random scan clock, values and enable drops
        scan_period = 0; scan_rand = 1'b1;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                value_in = 16'($urandom); dp_in = 4'($urandom);
            end
            if ($urandom_range(0, 59) == 0) enable = ~enable;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
